// File: rtl/encipher_pkg.sv
// Shared AES-128 sizes, FSM encoding and byte/field helpers for the encipher core.
package encipher_pkg;

   localparam int BLK_S  = 128;
   localparam int KEY_S  = 128;
   localparam int BYTE_S = 8;
   localparam int WORD_S = 32;
   localparam int Nk     = 4;
   localparam int Nr     = 10;

   localparam logic [Nk-1:0] LAST_ROUND = Nk'(Nr);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DONE
   } state_e;

   // Forward S-box; entry 0 sits in the most significant byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] get_sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] gm2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm3(input logic [7:0] b);
      return gm2(b) ^ b;
   endfunction

   function automatic logic [BYTE_S-1:0] get_byte(input logic [WORD_S-1:0] w, input int idx);
      return w[idx*BYTE_S +: BYTE_S];
   endfunction

   function automatic logic [WORD_S-1:0] get_word(input logic [BLK_S-1:0] blk, input int idx);
      return blk[idx*WORD_S +: WORD_S];
   endfunction

   function automatic logic [BYTE_S-1:0] blk_get_byte(input logic [BLK_S-1:0] blk, input int idx);
      return blk[idx*BYTE_S +: BYTE_S];
   endfunction

endpackage

// File: rtl/encipher_round.sv
// One combinational AES forward round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module encipher_round
   import encipher_pkg::*;
(
   input  logic [BLK_S-1:0] state_i,
   input  logic [KEY_S-1:0] key_i,
   input  logic             last_i,
   output logic [BLK_S-1:0] state_o
);

   logic [BLK_S-1:0] sub_s;
   logic [BLK_S-1:0] shift_s;
   logic [BLK_S-1:0] mix_s;

   genvar gi;

   // Column-major state: byte i is row i%4, column i/4, so ShiftRows is a 5*i stride.
   generate
      for (gi = 0; gi < 16; gi++) begin : g_byte
         assign sub_s[gi*BYTE_S +: BYTE_S]   = get_sbox(blk_get_byte(state_i, gi));
         assign shift_s[gi*BYTE_S +: BYTE_S] = blk_get_byte(sub_s, (5*gi) % 16);
      end

      for (gi = 0; gi < 4; gi++) begin : g_col
         logic [WORD_S-1:0] col;
         logic [7:0]        a0, a1, a2, a3;

         assign col = get_word(shift_s, gi);
         assign a0  = get_byte(col, 0);
         assign a1  = get_byte(col, 1);
         assign a2  = get_byte(col, 2);
         assign a3  = get_byte(col, 3);

         assign mix_s[gi*WORD_S +: WORD_S] = {
            gm3(a0) ^ a1      ^ a2      ^ gm2(a3),
            a0      ^ a1      ^ gm2(a2) ^ gm3(a3),
            a0      ^ gm2(a1) ^ gm3(a2) ^ a3,
            gm2(a0) ^ gm3(a1) ^ a2      ^ a3
         };
      end
   endgenerate

   assign state_o = (last_i ? shift_s : mix_s) ^ key_i;

endmodule

// File: rtl/encipher.sv
// Iterative AES-128 encryption core, one round per cycle against a registered key store.
// ENCIPHER_MASK_INTERMEDIATE_EN: when defined, ciphertext reads zero while busy.
module encipher
   import encipher_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [BLK_S-1:0] plaintext,
   input  logic [KEY_S-1:0] round_key,
   output logic [BLK_S-1:0] ciphertext,
   output logic [Nk-1:0]    round_no,
   output logic             busy,
   output logic             en_o
);

   state_e           state_q, state_d;
   logic [Nk-1:0]    round_no_q, round_no_d;
   logic [Nk-1:0]    rnd_q;
   logic [BLK_S-1:0] pt_q, pt_d;
   logic [BLK_S-1:0] s_q, s_d;
   logic [BLK_S-1:0] round_out;
   logic             last_round;

   // rnd_q trails round_no by one cycle so it lines up with the returned round_key.
   assign last_round = (rnd_q == LAST_ROUND);

   encipher_round u_round (
      .state_i (s_q),
      .key_i   (round_key),
      .last_i  (last_round),
      .state_o (round_out)
   );

   always_comb begin
      state_d    = state_q;
      round_no_d = round_no_q;
      pt_d       = pt_q;
      s_d        = s_q;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (en) begin
               state_d    = ST_LOAD;
               round_no_d = '0;
               pt_d       = plaintext;
            end else if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: state_d = ST_RUN;
         ST_RUN: begin
            s_d = (rnd_q == '0) ? (pt_q ^ round_key) : round_out;
            if (last_round) begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if ((state_q == ST_LOAD || state_q == ST_RUN) && round_no_q != LAST_ROUND) begin
         round_no_d = round_no_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         round_no_q <= '0;
         rnd_q      <= '0;
         pt_q       <= '0;
         s_q        <= '0;
      end else begin
         state_q    <= state_d;
         round_no_q <= round_no_d;
         rnd_q      <= round_no_q;
         pt_q       <= pt_d;
         s_q        <= s_d;
      end
   end

   assign round_no = round_no_q;
   assign busy     = (state_q == ST_LOAD) || (state_q == ST_RUN);
   assign en_o     = (state_q == ST_DONE);

`ifdef ENCIPHER_MASK_INTERMEDIATE_EN
   assign ciphertext = busy ? '0 : s_q;
`else
   assign ciphertext = s_q;
`endif

endmodule

// File: tb/tb_encipher.sv
// Directed-vector bench for encipher with a registered round-key store model.
module tb_encipher;

   logic         clk = 1'b0;
   logic         reset;
   logic         en;
   logic [127:0] plaintext;
   logic [127:0] round_key;
   logic [127:0] ciphertext;
   logic [3:0]   round_no;
   logic         busy;
   logic         en_o;

   int n_tests = 0;
   int n_fail  = 0;

   logic [127:0] rk_tbl [0:15];

   typedef struct {
      string        name;
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
   } vec_t;

   vec_t vecs [0:3];

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

   localparam logic [2047:0] TB_SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   encipher dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .plaintext  (plaintext),
      .round_key  (round_key),
      .ciphertext (ciphertext),
      .round_no   (round_no),
      .busy       (busy),
      .en_o       (en_o)
   );

   always #5 clk = ~clk;

   // Key store: registered read indexed by round_no.
   always @(posedge clk) round_key <= rk_tbl[round_no];

   function automatic logic [7:0] tb_sbox(input logic [7:0] b);
      return TB_SBOX[{~b, 3'b000} +: 8];
   endfunction

   // FIPS-197 printed order (byte 0 first) to the core's byte-0-at-LSB layout.
   function automatic logic [127:0] le(input logic [127:0] x);
      logic [127:0] y;
      for (int j = 0; j < 16; j++) y[j*8 +: 8] = x[(15-j)*8 +: 8];
      return y;
   endfunction

   task automatic load_key(input logic [127:0] key_f);
      logic [7:0] w [0:175];
      logic [7:0] t [0:3];
      logic [7:0] tmp;
      logic [7:0] rcon;
      rcon = 8'h01;
      for (int j = 0; j < 16; j++) w[j] = key_f[(15-j)*8 +: 8];
      for (int i = 4; i < 44; i++) begin
         for (int b = 0; b < 4; b++) t[b] = w[4*i-4+b];
         if (i % 4 == 0) begin
            tmp  = t[0];
            t[0] = tb_sbox(t[1]) ^ rcon;
            t[1] = tb_sbox(t[2]);
            t[2] = tb_sbox(t[3]);
            t[3] = tb_sbox(tmp);
            rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
         end
         for (int b = 0; b < 4; b++) w[4*i+b] = w[4*i-16+b] ^ t[b];
      end
      for (int r = 0; r < 11; r++)
         for (int j = 0; j < 16; j++) rk_tbl[r][j*8 +: 8] = w[16*r+j];
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Caller is at a negedge; en is raised here so the block starts at the next posedge.
   task automatic run_block(input string name, input logic [127:0] key_f, input logic [127:0] pt_f,
                            input logic [127:0] ct_f, input bit inject);
      int           lat, pulses, busy_err, rn_err;
      logic [127:0] pt_le, inter_act, inter_exp;
      logic [3:0]   rn_exp;
      load_key(key_f);
      pt_le     = le(pt_f);
      lat       = 0;
      pulses    = 0;
      busy_err  = 0;
      rn_err    = 0;
      inter_act = '0;
`ifdef ENCIPHER_MASK_INTERMEDIATE_EN
      inter_exp = '0;
`else
      inter_exp = pt_le ^ rk_tbl[0];
`endif
      en        = 1'b1;
      plaintext = pt_le;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         if (en_o === 1'b1) begin
            pulses++;
            if (lat == 0) lat = k;
         end
         if (busy !== (k <= 12)) busy_err++;
         rn_exp = (k > 11) ? 4'd10 : 4'(k - 1);
         if (round_no !== rn_exp) rn_err++;
`ifdef ENCIPHER_MASK_INTERMEDIATE_EN
         if (k <= 12) inter_act = inter_act | ciphertext;
`else
         if (k == 3) inter_act = ciphertext;
`endif
         en        = inject && (k == 3 || k == 9);
         plaintext = en ? 128'hdeadbeef_cafef00d_01234567_89abcdef : pt_le;
      end
      check({name, " en_o latency"}, 128'(lat), 128'd13);
      check({name, " en_o pulses"}, 128'(pulses), 128'd1);
      check({name, " busy errors"}, 128'(busy_err), 128'd0);
      check({name, " round_no errors"}, 128'(rn_err), 128'd0);
      check({name, " intermediate"}, inter_act, inter_exp);
      check({name, " ciphertext"}, ciphertext, le(ct_f));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      for (int r = 0; r < 16; r++) rk_tbl[r] = '0;
      vecs[0] = '{"C.1",  C1_KEY, C1_PT, C1_CT};
      vecs[1] = '{"AppB", B_KEY,  B_PT,  B_CT};
      vecs[2] = '{"zero", 128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
      vecs[3] = '{"ecb1", B_KEY,  128'h6bc1bee22e409f96e93d7e117393172a,
                  128'h3ad77bb40d7a3660a89ecaf32466ef97};

      reset     = 1'b1;
      en        = 1'b0;
      plaintext = '0;
      repeat (3) @(negedge clk);
      check("reset ciphertext", ciphertext, 128'h0);
      check("reset round_no", 128'(round_no), 128'd0);
      check("reset busy", 128'(busy), 128'd0);
      check("reset en_o", 128'(en_o), 128'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         run_block(vecs[i].name, vecs[i].key, vecs[i].pt, vecs[i].ct, 1'b0);
         en = 1'b0;
         @(negedge clk);
      end

      // Second start issued in the DONE cycle of the first.
      run_block("b2b first", B_KEY, B_PT, B_CT, 1'b0);
      run_block("b2b second", C1_KEY, C1_PT, C1_CT, 1'b0);
      en = 1'b0;
      @(negedge clk);

      run_block("ignored en", B_KEY, B_PT, B_CT, 1'b1);
      en = 1'b0;
      @(negedge clk);

      // Abort a block with reset in T+6.
      load_key(C1_KEY);
      en        = 1'b1;
      plaintext = le(C1_PT);
      @(negedge clk);
      en = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort busy", 128'(busy), 128'd0);
      check("abort round_no", 128'(round_no), 128'd0);
      check("abort ciphertext", ciphertext, 128'h0);
      pulses = (en_o === 1'b1) ? 1 : 0;
      repeat (12) begin
         @(negedge clk);
         if (en_o === 1'b1) pulses++;
      end
      check("abort en_o pulses", 128'(pulses), 128'd0);
      run_block("after abort", C1_KEY, C1_PT, C1_CT, 1'b0);
      en = 1'b0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/encipher.md
# encipher

Iterative AES-128 encryption core; the forward-direction counterpart of the decipher block. Computes one AES round per cycle and walks `round_no` upward from 0 to `Nr`. `round_no` drives the shared round-key store, which returns each key one cycle later. It sits between the input block buffer and the output packer, and shares the key store's read port protocol with decipher.

## Interface
- Parameters: none. Sizes come from `aes.vh`: `BLK_S`=128, `KEY_S`=128, `BYTE_S`=8, `WORD_S`=32, `Nk`=4, `Nr`=10.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` input, 1: clock.
- `reset` input, 1: synchronous, active-high.
- `en` input, 1: start pulse; sampled only when `busy`=0.
- `plaintext` input, `BLK_S`: block to encrypt; captured on the accepted `en` cycle.
- `round_key` input, `KEY_S`: key for the `round_no` value presented one cycle earlier (registered key-store read).
- `ciphertext` output, `BLK_S`: result; valid from the `en_o` cycle until the next start.
- `round_no` output, `Nk`: key-store read index.
- `busy` output, 1: operation in progress.
- `en_o` output, 1: one-cycle done pulse.

## Operation
- Byte order:
  - Byte i of a block is `[i*8 +: 8]`; FIPS-197 byte 0 is at bits [7:0].
  - State is column-major, so byte i is row i%4, column i/4.
- ShiftRows: out byte i = in byte (5*i) mod 16.
- MixColumns per word: `{2,3,1,1}` circulant, using the shared `gm2`/`gm3` helpers.
- Round functions, with `r` the round index and `k_r` its key:
  - r=0: s = plaintext_reg ^ k_0.
  - r=1..9: s = MixColumns(ShiftRows(SubBytes(s))) ^ k_r.
  - r=10: s = ShiftRows(SubBytes(s)) ^ k_10.
- States:
  - IDLE → LOAD on accepted `en`.
  - LOAD → RUN after 1 cycle (key-read latency).
  - RUN: one round per cycle; after round 10 → DONE.
  - DONE → IDLE after 1 cycle, with `en_o`=1.
- `round_no`:
  - Set to 0 on the `en` edge, then increments each cycle until it reaches 10.
  - Holds 10 until the next start. It never wraps.
- Round index used by the datapath is a copy of `round_no` delayed one cycle (pairs with `round_key`).
- `en` while `busy`=1: ignored; no restart, no effect on state.
- `en` in the DONE cycle: accepted; that cycle is not busy.
- Reset values:
  - `ciphertext`=0, `round_no`=0, `busy`=0, `en_o`=0, state=IDLE.
- Reset mid-operation:
  - Returns to IDLE on the next edge.
  - No `en_o` for the aborted block.
  - `ciphertext` is cleared.

## Timing
- Take the accepted `en` in cycle T.
- `round_no`:
  - `round_no`=0 in T+1.
  - `round_no`=r in T+1+r.
  - `round_no`=10 from T+11 onward.
- `round_key`: `k_r` present in T+2+r; state register updated at the end of T+2+r.
- `busy`: 1 for T+1..T+12.
- `en_o`: 1 in T+13 only, with `ciphertext` final.
- Latency: 13 cycles from `en` to `en_o`.
- Maximum throughput: one block per 13 cycles (back-to-back `en` at T+13).

## Configuration
- `ENCIPHER_MASK_INTERMEDIATE_EN` defined:
  - `ciphertext` reads 0 while `busy`=1.
  - Intermediate round states are never exposed.
- Not defined: `ciphertext` is the state register directly; intermediate values are visible during `busy`.
- The final value and all cycle timing are identical in both builds.

## Structure
- Shared in `aes.vh` / `aes_common.vh`:
  - Size macros.
  - Forward `sbox` table with `get_sbox`.
  - `gm2`/`gm3`.
  - `get_byte`/`get_word`/`blk_get_byte`.
  - State encodings as localparams.
- Sub-module `encipher_round`: purely combinational; inputs s, key, last-round flag; output next s.
- FSM, counters and registers stay in `encipher`.

## Test plan
- FIPS-197 C.1:
  - Stimulus: key `000102030405060708090a0b0c0d0e0f`, plaintext `00112233445566778899aabbccddeeff`.
  - Required: `ciphertext` `69c4e0d86a7b0430d8cdb78070b4c55a` with `en_o` exactly 13 cycles after `en`.
- Round-number sequence: FIPS-197 App. B block → `round_no` 0,1,…,10 in T+1..T+11, then holds 10.
- Back-to-back:
  - Stimulus: App. B block (key `2b7e151628aed2a6abf7158809cf4f3c`, plaintext `3243f6a8885a308d313198a2e0370734`), then the C.1 block with `en` at T+13.
  - Required: `3925841d02dc09fbdc118597196a0b32`, then `69c4e0d8…c55a`, with two `en_o` pulses 13 cycles apart.
- Ignored start: `en` pulses at T+3 and T+9 with a different `plaintext` → result unchanged; single `en_o` at T+13.
- Reset mid-operation:
  - Stimulus: `reset` at T+6.
  - Required: `busy`=0, `round_no`=0 and `ciphertext`=0 next cycle; no `en_o`; a new `en` afterwards gives the correct result.
- `ENCIPHER_MASK_INTERMEDIATE_EN` build: C.1 vector → `ciphertext`==0 for T+1..T+12, correct value at T+13.
